time_reader: RTL and testbench

- Host-side readout port for the 64-bit epoch counter produced by `timer`.
- On request, takes a coherent snapshot of `o_time` into a shadow register, then streams it out one byte at a time over a valid/ready handshake.
- Sits between `timer.o_time` and the host bus/UART front end. It is the read path, complementing the `i_time`/`load_enable` write path.

---
 rtl/time_reader.sv | 120 ++++++++++++
 tb/tb_time_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_reader.sv
// time_reader: host-side readout of the 64-bit epoch counter.
// A request in IDLE snapshots i_time into a shadow register. The snapshot is
// then streamed out one byte per valid/ready transfer. Byte order is set by
// MSB_FIRST.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no snapshot in flight, waiting for req
// ST_SEND | shadow holds a snapshot, o_data/o_last present byte idx_q
module time_reader #(
  parameter int TIME_WIDTH = 64,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [TIME_WIDTH-1:0] i_time,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  busy
);

  localparam int NBYTES = TIME_WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [TIME_WIDTH-1:0] shadow_q, shadow_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [IDXW-1:0]       idx_inc;
  logic [7:0]            data_q, data_d;
  logic                  capture;
  logic                  xfer;
  logic                  xfer_last;

  // Byte 'idx' of the stream, counted in send order.
  function automatic logic [7:0] pick_byte(input logic [TIME_WIDTH-1:0] word,
                                           input logic [IDXW-1:0]       idx);
    logic [IDXW-1:0]       sel;
    logic [TIME_WIDTH-1:0] shifted;
    sel     = MSB_FIRST ? (LAST_IDX - idx) : idx;
    shifted = word >> {sel, 3'b000};
    return shifted[7:0];
  endfunction

  assign capture   = (state_q == ST_IDLE) && req;
  assign xfer      = (state_q == ST_SEND) && i_ready;
  assign xfer_last = xfer && (idx_q == LAST_IDX);
  assign idx_inc   = idx_q + IDXW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: req only matters in IDLE, the last transfer ends SEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req)       state_d = ST_SEND;
      ST_SEND: if (xfer_last) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output decode; valid/busy/last come straight from registered state so they
  // drop together with the asynchronous reset.
  always_comb begin
    o_valid = (state_q == ST_SEND);
    busy    = (state_q == ST_SEND);
    o_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
  end

  // Datapath next values: load the snapshot and its first byte on capture,
  // advance to the following byte on each non-final transfer, hold otherwise.
  // The first byte is picked from i_time directly so o_data is ready in the
  // cycle right after the capture edge.
  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    data_d   = data_q;
    if (capture) begin
      shadow_d = i_time;
      idx_d    = '0;
      data_d   = pick_byte(i_time, '0);
    end else if (xfer_last) begin
      idx_d    = '0;
    end else if (xfer) begin
      idx_d    = idx_inc;
      data_d   = pick_byte(shadow_q, idx_inc);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_time_reader.sv
// Bench for time_reader: one MSB-first and one LSB-first instance share the
// stimulus; a small divider/timer model provides a live time source.
module tb_time_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        i_ready;
  logic [63:0] tv;
  logic [63:0] i_time;
  logic [7:0]  o_data_m, o_data_l;
  logic        o_valid_m, o_valid_l;
  logic        o_last_m, o_last_l;
  logic        busy_m, busy_l;

  // divider at BASE_FREQ=4 feeding an epoch timer
  logic        tm_rst;
  logic [1:0]  div_q;
  logic [63:0] t_q;
  logic        one_hz;
  logic        use_timer;

  int n_tot = 0;
  int n_bad = 0;

  logic [7:0] seq_m[8];
  logic [7:0] seq_l[8];

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge tm_rst) begin
    if (tm_rst) begin
      div_q <= '0;
      t_q   <= '0;
    end else begin
      div_q <= div_q + 2'd1;
      if (one_hz) t_q <= t_q + 64'd1;
    end
  end
  assign one_hz = (div_q == 2'd3);
  assign i_time = use_timer ? t_q : tv;

  time_reader #(.TIME_WIDTH(64), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .req(req), .i_time(i_time),
    .o_data(o_data_m), .o_valid(o_valid_m), .i_ready(i_ready),
    .o_last(o_last_m), .busy(busy_m)
  );

  time_reader #(.TIME_WIDTH(64), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .req(req), .i_time(i_time),
    .o_data(o_data_l), .o_valid(o_valid_l), .i_ready(i_ready),
    .o_last(o_last_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Collect 8 bytes from both instances, assuming i_ready=1 and SEND byte 0 showing.
  task automatic grab(output logic [63:0] sm, output logic [63:0] sl);
    sm = '0;
    sl = '0;
    for (int k = 0; k < 8; k++) begin
      sm = {sm[55:0], o_data_m};
      sl = {o_data_l, sl[63:8]};
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sm, sl, cap_exp;
    logic [7:0]  prev_m, prev_l;
    logic        stall_prev, r, found, prev_busy;
    int          k, cyc, nrise;
    int          rise[4];

    seq_m = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    seq_l = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

    rst = 1'b1; tm_rst = 1'b1; req = 1'b0; i_ready = 1'b0;
    tv = '0; use_timer = 1'b0;
    #1;
    chk("rst_valid_m", o_valid_m, 0);
    chk("rst_busy_m",  busy_m,    0);
    chk("rst_last_m",  o_last_m,  0);
    chk("rst_data_m",  o_data_m,  0);
    chk("rst_valid_l", o_valid_l, 0);
    chk("rst_busy_l",  busy_l,    0);
    repeat (2) @(negedge clk);
    rst = 1'b0; tm_rst = 1'b0;
    @(negedge clk);

    // scenarios 1 and 2: plain readout, both byte orders
    tv = 64'h0123_4567_89AB_CDEF; i_ready = 1'b1;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s1_valid%0d", i), o_valid_m, 1);
      chk($sformatf("s1_busy%0d", i),  busy_m,    1);
      chk($sformatf("s1_data%0d", i),  o_data_m,  seq_m[i]);
      chk($sformatf("s1_last%0d", i),  o_last_m,  (i == 7));
      chk($sformatf("s2_data%0d", i),  o_data_l,  seq_l[i]);
      chk($sformatf("s2_last%0d", i),  o_last_l,  (i == 7));
      @(negedge clk);
    end
    chk("s1_end_valid", o_valid_m, 0);
    chk("s1_end_busy",  busy_m,    0);
    chk("s1_end_last",  o_last_m,  0);
    chk("s2_end_valid", o_valid_l, 0);
    chk("s2_end_busy",  busy_l,    0);
    @(negedge clk);

    // scenario 3: random backpressure, i_time scrambled during SEND
    tv = 64'h0123_4567_89AB_CDEF;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    k = 0; cyc = 0; stall_prev = 1'b0; prev_m = '0; prev_l = '0;
    while (k < 8 && cyc < 200) begin
      chk($sformatf("s3_valid%0d", cyc), o_valid_m, 1);
      chk($sformatf("s3_data_m%0d", cyc), o_data_m, seq_m[k]);
      chk($sformatf("s3_data_l%0d", cyc), o_data_l, seq_l[k]);
      chk($sformatf("s3_last%0d", cyc), o_last_m, (k == 7));
      if (stall_prev) begin
        chk($sformatf("s3_stable_m%0d", cyc), o_data_m, prev_m);
        chk($sformatf("s3_stable_l%0d", cyc), o_data_l, prev_l);
      end
      prev_m = o_data_m;
      prev_l = o_data_l;
      r = 1'($urandom_range(0, 1));
      i_ready = r;
      tv = {$urandom, $urandom};
      @(negedge clk);
      if (r) k++;
      stall_prev = !r;
      cyc++;
    end
    chk("s3_count", k, 8);
    chk("s3_end_valid", o_valid_m, 0);
    chk("s3_end_busy",  busy_m,    0);
    i_ready = 1'b1;
    @(negedge clk);

    // scenario 4: coherence against the live timer
    use_timer = 1'b1;
    tm_rst = 1'b1;
    @(negedge clk);
    tm_rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (one_hz && t_q == 64'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("s4_find", found, 1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("s4_valid", o_valid_m, 1);
    grab(sm, sl);
    chk("s4_snap_m", sm, 64'd5);
    chk("s4_snap_l", sl, 64'd5);
    chk("s4_idle", busy_m, 0);
    cap_exp = t_q;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    grab(sm, sl);
    chk("s4_next_m", sm, cap_exp);
    chk("s4_next_ge6", (sm >= 64'd6), 1);
    use_timer = 1'b0;
    @(negedge clk);

    // scenario 5a: req held high, capture every 9 cycles
    tv = 64'hDEAD_BEEF_0000_0001;
    req = 1'b1;
    prev_busy = busy_m;
    nrise = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_m && !prev_busy && nrise < 4) begin
        rise[nrise] = c;
        nrise++;
      end
      prev_busy = busy_m;
    end
    req = 1'b0;
    chk("s5_nrise", (nrise >= 3), 1);
    if (nrise >= 3) begin
      chk("s5_gap0", rise[1] - rise[0], 9);
      chk("s5_gap1", rise[2] - rise[1], 9);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!busy_m) found = 1'b1;
      else @(negedge clk);
    end
    chk("s5_drain", found, 1);
    @(negedge clk);

    // scenario 5b: asynchronous reset mid-SEND, then clean restart
    tv = 64'h0123_4567_89AB_CDEF;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("s5_pre_data", o_data_m, 8'h67);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_valid", o_valid_m, 0);
    chk("s5_rst_busy",  busy_m,    0);
    chk("s5_rst_last",  o_last_m,  0);
    chk("s5_rst_data",  o_data_m,  0);
    chk("s5_rst_valid_l", o_valid_l, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("s5_restart_byte0", o_data_m, 8'h01);
    grab(sm, sl);
    chk("s5_restart_m", sm, 64'h0123_4567_89AB_CDEF);
    chk("s5_restart_l", sl, 64'h0123_4567_89AB_CDEF);
    chk("s5_restart_idle", busy_m, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
